// File: rtl/trip_controller.sv
`default_nettype none
// ============================================================================
// Module   : trip_controller
// Purpose  : Sequencer for the trip distance counter. Synchronises and
//            debounces the raw reed switch into single-cycle wheel pulses,
//            runs the trip state machine (IDLE/RUN/PAUSE/CLEAR), gates the
//            distance counter enable, issues the trip clear pulse and holds
//            the validated wheel circumference.
// Build    : AUTO_PAUSE_EN defined   -> idle counter and RUN timeout present.
//            AUTO_PAUSE_EN undefined -> PAUSE entered/left by buttons only,
//                                       auto_paused tied to 0.
// Ports    : clock, reset      system clock, synchronous active-high reset
//            reed_raw          asynchronous reed switch level
//            btn_start         1-cycle start/stop toggle
//            btn_clear         1-cycle clear trip
//            circ_in/circ_load new circumference (cm) and its strobe
//            reed_pulse        1-cycle pulse per accepted wheel revolution
//            dist_enable       count enable (high in RUN)
//            trip_reset        1-cycle clear to distance counter/trip timer
//            circ              active circumference (cm)
//            circ_err          1-cycle pulse when a circ_load is rejected
//            state             00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR
//            auto_paused       high while in PAUSE entered by timeout
// Revision : 1.0  initial release
// ============================================================================
module trip_controller #(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int AUTOPAUSE_CYC = 3000,
  parameter int CIRC_DEFAULT  = 218,
  parameter int CIRC_MIN      = 100,
  parameter int CIRC_MAX      = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reed_raw,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic [7:0] circ_in,
  input  logic       circ_load,
  output logic       reed_pulse,
  output logic       dist_enable,
  output logic       trip_reset,
  output logic [7:0] circ,
  output logic       circ_err,
  output logic [1:0] state,
  output logic       auto_paused
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  localparam int         c_LOCK_W       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [7:0] c_CIRC_DEFAULT = 8'(CIRC_DEFAULT);
  localparam logic [7:0] c_CIRC_MIN     = 8'(CIRC_MIN);
  localparam logic [7:0] c_CIRC_MAX     = 8'(CIRC_MAX);

  // --------------------------------------------------------------------------
  // Reed path: 2-flop synchroniser, edge register, lockout counter
  // --------------------------------------------------------------------------
  logic                r_sync1;
  logic                r_sync2;
  logic                r_reed_d;
  logic [c_LOCK_W-1:0] r_lockout;
  logic                r_reed_pulse;
  logic                w_reed_rise;

  assign w_reed_rise = r_sync2 & ~r_reed_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_reed_d     <= 1'b0;
      r_lockout    <= '0;
      r_reed_pulse <= 1'b0;
    end else begin
      r_sync1  <= reed_raw;
      r_sync2  <= r_sync1;
      r_reed_d <= r_sync2;
      // Edges seen while locked out are discarded outright, never queued.
      if (w_reed_rise && (r_lockout == '0)) begin
        r_reed_pulse <= 1'b1;
        r_lockout    <= c_LOCK_W'(DEBOUNCE_CYC - 1);
      end else begin
        r_reed_pulse <= 1'b0;
        if (r_lockout != '0) begin
          r_lockout <= r_lockout - c_LOCK_W'(1);
        end
      end
    end
  end

  assign reed_pulse = r_reed_pulse;

  // --------------------------------------------------------------------------
  // Trip state machine
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_next_state;
  logic   r_dist_enable;
  logic   r_trip_reset;
  logic   w_timeout;
  logic   w_auto_paused;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (btn_clear)      w_next_state = ST_CLEAR;
        else if (btn_start) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (btn_clear)      w_next_state = ST_CLEAR;
        else if (btn_start) w_next_state = ST_PAUSE;
        else if (w_timeout) w_next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (btn_clear)      w_next_state = ST_CLEAR;
        else if (btn_start) w_next_state = ST_RUN;
        // The waking pulse itself is not counted: dist_enable rises after it.
        else if (w_auto_paused && r_reed_pulse) w_next_state = ST_RUN;
      end
      ST_CLEAR: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dist_enable <= 1'b0;
      r_trip_reset  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_dist_enable <= (w_next_state == ST_RUN);
      r_trip_reset  <= (w_next_state == ST_CLEAR);
    end
  end

  assign state       = r_state;
  assign dist_enable = r_dist_enable;
  assign trip_reset  = r_trip_reset;

  // --------------------------------------------------------------------------
  // Idle counter and auto-pause flag
  // --------------------------------------------------------------------------
`ifdef AUTO_PAUSE_EN
  localparam int                c_IDLE_W   = $clog2(AUTOPAUSE_CYC + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(AUTOPAUSE_CYC);
  localparam logic [c_IDLE_W-1:0] c_IDLE_TO  = c_IDLE_W'(AUTOPAUSE_CYC - 1);

  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic                r_auto_paused;
  logic                w_auto_next;

  // A reed pulse in the timeout cycle keeps the block in RUN.
  assign w_timeout = (r_state == ST_RUN) && (r_idle_cnt == c_IDLE_TO) &&
                     !r_reed_pulse;

  // Only a timeout-driven entry marks the pause as automatic; staying in
  // PAUSE keeps the flag, any other transition clears it.
  assign w_auto_next = (w_next_state == ST_PAUSE) &&
                       ((r_state == ST_PAUSE) ? r_auto_paused
                                              : (!btn_clear && !btn_start && w_timeout));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt    <= '0;
      r_auto_paused <= 1'b0;
    end else begin
      r_auto_paused <= w_auto_next;
      if (((r_state != ST_RUN) && (w_next_state == ST_RUN)) || r_reed_pulse) begin
        r_idle_cnt <= '0;
      end else if ((r_state == ST_RUN) && (r_idle_cnt != c_IDLE_MAX)) begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end
    end
  end

  assign w_auto_paused = r_auto_paused;
`else
  assign w_timeout     = 1'b0;
  assign w_auto_paused = 1'b0;
`endif

  assign auto_paused = w_auto_paused;

  // --------------------------------------------------------------------------
  // Circumference register: loads accepted only in IDLE and within range
  // --------------------------------------------------------------------------
  logic [7:0] r_circ;
  logic       r_circ_err;
  logic       w_circ_ok;

  assign w_circ_ok = circ_load && (r_state == ST_IDLE) &&
                     (circ_in >= c_CIRC_MIN) && (circ_in <= c_CIRC_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_circ     <= c_CIRC_DEFAULT;
      r_circ_err <= 1'b0;
    end else begin
      r_circ_err <= circ_load && !w_circ_ok;
      if (w_circ_ok) begin
        r_circ <= circ_in;
      end
    end
  end

  assign circ     = r_circ;
  assign circ_err = r_circ_err;

endmodule
`default_nettype wire

// File: tb/tb_trip_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_trip_controller
// Purpose  : Self-checking bench for trip_controller. Directed scenarios plus
//            randomized reed/button/load traffic, every cycle compared with a
//            behavioural model built from event timestamps (last accepted
//            pulse, start of the current idle interval) and sample history.
// Build    : AUTO_PAUSE_EN selects the auto-pause expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_trip_controller;

  localparam int DEB  = 16;
  localparam int AP   = 3000;
  localparam int CDEF = 218;
  localparam int CMIN = 100;
  localparam int CMAX = 250;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reed_raw = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] circ_in = 8'd0;
  logic       circ_load = 1'b0;
  logic       reed_pulse;
  logic       dist_enable;
  logic       trip_reset;
  logic [7:0] circ;
  logic       circ_err;
  logic [1:0] state;
  logic       auto_paused;

  trip_controller #(
    .DEBOUNCE_CYC (DEB),
    .AUTOPAUSE_CYC(AP),
    .CIRC_DEFAULT (CDEF),
    .CIRC_MIN     (CMIN),
    .CIRC_MAX     (CMAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .reed_raw   (reed_raw),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .circ_in    (circ_in),
    .circ_load  (circ_load),
    .reed_pulse (reed_pulse),
    .dist_enable(dist_enable),
    .trip_reset (trip_reset),
    .circ       (circ),
    .circ_err   (circ_err),
    .state      (state),
    .auto_paused(auto_paused)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state; cycle k is the interval following posedge k.
  longint     k = 0;
  logic [1:0] m_state = S_IDLE;
  bit         m_auto, m_dist, m_trip, m_err, m_pulse;
  logic [7:0] m_circ = 8'(CDEF);
  longint     m_last_pulse = -1000;   // cycle of last accepted reed pulse
  longint     m_ref = 0;              // first cycle of current idle interval
  bit         h0, h1, h2, h3;         // reed_raw samples at edges k..k-3

  task model_update();
    logic [1:0] ps;
    logic [1:0] ns;
    bit pp, pa, to, na;
    k++;
    if (reset) begin
      m_state = S_IDLE; m_auto = 0; m_dist = 0; m_trip = 0; m_err = 0;
      m_pulse = 0; m_circ = 8'(CDEF); m_last_pulse = -1000; m_ref = k;
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      return;
    end
    ps = m_state; pp = m_pulse; pa = m_auto;
`ifdef AUTO_PAUSE_EN
    to = (ps == S_RUN) && (((k - 1) - m_ref) == longint'(AP - 1)) && !pp;
`else
    to = 0;
`endif
    ns = ps; na = 0;
    if (ps == S_CLEAR) ns = S_IDLE;
    else if (btn_clear) ns = S_CLEAR;
    else if (ps == S_IDLE && btn_start) ns = S_RUN;
    else if (ps == S_RUN && btn_start) ns = S_PAUSE;
    else if (ps == S_RUN && to) begin ns = S_PAUSE; na = 1; end
    else if (ps == S_PAUSE && btn_start) ns = S_RUN;
    else if (ps == S_PAUSE && pa && pp) ns = S_RUN;
    else if (ps == S_PAUSE) na = pa;
    m_err = 0;
    if (circ_load) begin
      if (ps == S_IDLE && int'(circ_in) >= CMIN && int'(circ_in) <= CMAX)
        m_circ = circ_in;
      else
        m_err = 1;
    end
    if ((ns == S_RUN && ps != S_RUN) || pp) m_ref = k;
    m_state = ns; m_auto = na;
    m_dist = (ns == S_RUN); m_trip = (ns == S_CLEAR);
    h3 = h2; h2 = h1; h1 = h0; h0 = reed_raw;
    m_pulse = h2 && !h3 && ((k - m_last_pulse) >= longint'(DEB));
    if (m_pulse) m_last_pulse = k;
  endtask

  task check_outputs();
    logic [14:0] obs, exp;
    obs = {reed_pulse, dist_enable, trip_reset, circ, circ_err, state, auto_paused};
    exp = {m_pulse, m_dist, m_trip, m_circ, m_err, m_state, m_auto};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL cycle%0d outputs{pulse,en,trst,circ,err,state,auto}: observed %h expected %h",
             k, obs, exp);
    end
  endtask

  task chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model the edge, check outputs, drop the 1-cycle strobes.
  task step();
    @(posedge clock);
    model_update();
    #1;
    check_outputs();
    btn_start = 0; btn_clear = 0; circ_load = 0;
  endtask

  task load(input int value);
    circ_in = 8'(value); circ_load = 1; step();
  endtask

  int npulse, pos, cyc;
  bit en_ok;
  logic [9:0] pat;

  initial begin
    // ---- 1: reset, start, three clean revolutions ----
    reset = 1; repeat (3) step();
    reset = 0; step();
    chk("reset_state", int'(state), int'(S_IDLE));
    chk("reset_circ", int'(circ), CDEF);
    chk("reset_outputs", int'({reed_pulse, dist_enable, trip_reset, circ_err, auto_paused}), 0);
    btn_start = 1; step();
    chk("start_to_run", int'(state), int'(S_RUN));
    npulse = 0; en_ok = 1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 100; c++) begin
        reed_raw = (c < 5);
        step();
        if (reed_pulse) npulse++;
        if (!dist_enable || state != S_RUN) en_ok = 0;
      end
    end
    chk("three_revs_pulses", npulse, 3);
    chk("three_revs_enabled", int'(en_ok), 1);

    // ---- 2: bouncing contact -> a single pulse, 3rd cycle after first high ----
    pat = 10'b0101010101;
    npulse = 0; pos = 0;
    for (int i = 0; i < 10; i++) begin
      reed_raw = pat[i];
      step();
      if (reed_pulse) begin npulse++; if (pos == 0) pos = i + 1; end
    end
    reed_raw = 0;
    repeat (30) begin step(); if (reed_pulse) npulse++; end
    chk("bounce_pulses", npulse, 1);
    chk("bounce_latency", pos, 3);

    // ---- 3: idle timeout ----
`ifdef AUTO_PAUSE_EN
    for (cyc = 0; cyc < 4000 && state != S_PAUSE; cyc++) step();
    chk("autopause_state", int'(state), int'(S_PAUSE));
    chk("autopause_flag", int'(auto_paused), 1);
    chk("autopause_dist_en", int'(dist_enable), 0);
    reed_raw = 1;
    for (cyc = 0; cyc < 8 && !reed_pulse; cyc++) step();
    chk("wake_pulse_seen", int'(reed_pulse), 1);
    chk("wake_pulse_uncounted", int'(dist_enable), 0);
    reed_raw = 0; step();
    chk("wake_state", int'(state), int'(S_RUN));
    chk("wake_dist_en", int'(dist_enable), 1);
    // pulse landing exactly on the timeout cycle keeps RUN
    for (cyc = 0; cyc < 4000 && k != m_ref + AP - 4; cyc++) step();
    reed_raw = 1; repeat (3) step();
    chk("collide_pulse", int'(reed_pulse), 1);
    reed_raw = 0; step();
    chk("collide_stays_run", int'(state), int'(S_RUN));
`else
    repeat (AP + 100) step();
    chk("no_autopause_state", int'(state), int'(S_RUN));
    chk("no_autopause_flag", int'(auto_paused), 0);
    btn_start = 1; step();
    chk("manual_pause", int'(state), int'(S_PAUSE));
    btn_start = 1; step();
    chk("manual_resume", int'(state), int'(S_RUN));
`endif

    // ---- 4: start and clear together in RUN ----
    btn_start = 1; btn_clear = 1; step();
    chk("clear_wins_state", int'(state), int'(S_CLEAR));
    chk("clear_trip_reset", int'(trip_reset), 1);
    step();
    chk("clear_to_idle", int'(state), int'(S_IDLE));
    chk("clear_trip_reset_drop", int'(trip_reset), 0);

    // ---- 5: circumference loads ----
    load(200);
    chk("circ_200", int'(circ), 200);
    chk("circ_200_err", int'(circ_err), 0);
    load(90);
    chk("circ_90_err", int'(circ_err), 1);
    chk("circ_90_held", int'(circ), 200);
    load(CMIN);       chk("circ_min", int'(circ), CMIN);
    load(CMIN - 1);   chk("circ_min_m1_err", int'(circ_err), 1);
    load(CMAX);       chk("circ_max", int'(circ), CMAX);
    load(CMAX + 1);   chk("circ_max_p1_err", int'(circ_err), 1);
    load(200);
    btn_start = 1; step();
    load(150);
    chk("circ_run_err", int'(circ_err), 1);
    chk("circ_run_held", int'(circ), 200);
    btn_clear = 1; step();
    load(150);
    chk("circ_clear_err", int'(circ_err), 1);
    chk("circ_clear_held", int'(circ), 200);

    // ---- 6: reset while in CLEAR ----
    btn_clear = 1; step();
    chk("pre_reset_clear", int'(state), int'(S_CLEAR));
    reset = 1; step();
    chk("reset_in_clear_state", int'(state), int'(S_IDLE));
    chk("reset_in_clear_trst", int'(trip_reset), 0);
    chk("reset_in_clear_circ", int'(circ), CDEF);
    reset = 0; step();

    // ---- randomized traffic: busy then sparse ----
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 24) == 0) reed_raw = ~reed_raw;
      btn_start = ($urandom_range(0, 149) == 0);
      btn_clear = ($urandom_range(0, 599) == 0);
      circ_load = ($urandom_range(0, 79) == 0);
      circ_in   = 8'($urandom_range(60, 255));
      reset     = ($urandom_range(0, 3999) == 0);
      step();
    end
    reset = 0;
    for (int i = 0; i < 14000; i++) begin
      if ($urandom_range(0, 1499) == 0) reed_raw = ~reed_raw;
      btn_start = ($urandom_range(0, 1999) == 0);
      btn_clear = ($urandom_range(0, 5999) == 0);
      circ_load = ($urandom_range(0, 299) == 0);
      circ_in   = 8'($urandom_range(60, 255));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
